// File: rtl/free_list_if.sv
// free_list_if: rename-side and retire-side signals of the free list.
// Ports (slave = free list):
//   alloc_req, retire_en, retire_old_idx  -> into the free list
//   alloc_idx, alloc_ok, free_count       <- out of the free list
// Latency: none of its own; this is wiring only.
// Backpressure: alloc_ok low means rename must stall and retry the same request.
interface free_list_if #(
  parameter int WAYS = 4,
  parameter int PRF  = 64,
  parameter int ARCH = 32
) ();
  localparam int TW = $clog2(PRF);
  localparam int CW = $clog2(PRF - ARCH) + 1;

  // Rename side
  logic [WAYS-1:0]          alloc_req;
  logic [WAYS-1:0][TW-1:0]  alloc_idx;
  logic                     alloc_ok;
  logic [CW-1:0]            free_count;

  // Retirement side
  logic [WAYS-1:0]          retire_en;
  logic [WAYS-1:0][TW-1:0]  retire_old_idx;

  modport master (
    output alloc_req, retire_en, retire_old_idx,
    input  alloc_idx, alloc_ok, free_count
  );

  modport slave (
    input  alloc_req, retire_en, retire_old_idx,
    output alloc_idx, alloc_ok, free_count
  );
endinterface

// File: rtl/free_list.sv
// free_list: circular FIFO of free physical register tags for rename / retire.
// Latency: tags are offered combinationally from registered state; retired tags
//          become allocatable one cycle after retirement (no bypass).
// Backpressure: all-or-nothing grant; alloc_ok low consumes nothing and rename stalls.
//
// Ports:
//   clock, reset  : system clock, synchronous active-high reset
//   except        : recovery; drops every speculative allocation in one cycle
//   fl (slave)    : alloc_req/alloc_idx/alloc_ok/free_count (rename),
//                   retire_en/retire_old_idx (retirement)
//   err           : only with FREELIST_CHECK_EN defined; sticky protocol error
//
// Build option: define FREELIST_CHECK_EN to add the err output and its checks.
//
// Ring layout (positions modulo DEPTH):
//   head_retire .. head_alloc : tags handed out but not yet retired
//   head_alloc  .. tail       : free tags (count of them)
// Retirement is in order, so the oldest outstanding allocation is always the
// one being retired; head_retire just follows it. On except the free window is
// re-extended back to head_retire, which returns every speculative tag at once.
module free_list #(
  parameter int WAYS = 4,
  parameter int PRF  = 64,
  parameter int ARCH = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       except,
  free_list_if.slave fl
`ifdef FREELIST_CHECK_EN
  ,
  output logic       err
`endif
);

  localparam int DEPTH = PRF - ARCH;
  localparam int TW    = $clog2(PRF);
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int RW    = $clog2(WAYS + 1);

  typedef logic [TW-1:0] tag_t;
  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;
  typedef logic [RW-1:0] pop_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  tag_t mem [DEPTH];
  ptr_t head_alloc_q;
  ptr_t head_retire_q;
  ptr_t tail_q;
  cnt_t count_q;

  ptr_t head_alloc_d;
  ptr_t head_retire_d;
  ptr_t tail_d;
  cnt_t count_d;

  // Pointer advance with wrap; k never exceeds WAYS, which is at most DEPTH,
  // so a single conditional subtract covers non-power-of-two depths too.
  function automatic ptr_t ptr_add(input ptr_t p, input pop_t k);
    int s;
    s = int'(p) + int'(k);
    if (s >= DEPTH) begin
      s = s - DEPTH;
    end
    return ptr_t'(s);
  endfunction

  // ---------------------------------------------------------------------------
  // Per-way ranks: how many set bits lie below each way. This is the offset of
  // that way's slot from the relevant pointer, so sparse patterns stay dense
  // in the ring.
  // ---------------------------------------------------------------------------
  pop_t [WAYS-1:0] req_rank;
  pop_t [WAYS-1:0] ret_rank;
  pop_t            alloc_n;
  pop_t            ret_n;

  always_comb begin : alloc_rank
    pop_t acc;
    acc = '0;
    for (int i = 0; i < WAYS; i++) begin
      req_rank[i] = acc;
      acc = acc + pop_t'(fl.alloc_req[i]);
    end
    alloc_n = acc;
  end

  always_comb begin : retire_rank
    pop_t acc;
    acc = '0;
    for (int i = 0; i < WAYS; i++) begin
      ret_rank[i] = acc;
      acc = acc + pop_t'(fl.retire_en[i]);
    end
    ret_n = acc;
  end

  // ---------------------------------------------------------------------------
  // Allocation (combinational from registered state)
  // ---------------------------------------------------------------------------
  ptr_t [WAYS-1:0] rd_ptr;
  ptr_t [WAYS-1:0] wr_ptr;
  logic            grant;

  always_comb begin : offer
    for (int i = 0; i < WAYS; i++) begin
      // Idle ways just show the head entry; only requesting ways are offset.
      rd_ptr[i] = ptr_add(head_alloc_q, fl.alloc_req[i] ? req_rank[i] : '0);
      fl.alloc_idx[i] = mem[rd_ptr[i]];
    end
  end

  // Uses the pre-update count: tags retired this cycle are not yet visible.
  assign fl.alloc_ok   = (int'(alloc_n) <= int'(count_q));
  assign fl.free_count = count_q;

  // A recovery cycle never consumes tags, even when alloc_ok is high.
  assign grant = fl.alloc_ok & ~except;

  // ---------------------------------------------------------------------------
  // Retirement write slots: way order maps to consecutive slots from tail.
  // ---------------------------------------------------------------------------
  always_comb begin : retire_slot
    for (int i = 0; i < WAYS; i++) begin
      wr_ptr[i] = ptr_add(tail_q, ret_rank[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state
  // ---------------------------------------------------------------------------
  always_comb begin : next_state
    int c;
    c             = 0;
    head_retire_d = ptr_add(head_retire_q, ret_n);
    tail_d        = ptr_add(tail_q, ret_n);
    head_alloc_d  = head_alloc_q;
    count_d       = count_q;

    if (except) begin
      // Everything between the (post-retire) retirement pointer and tail is
      // free again, which is the whole ring.
      head_alloc_d = head_retire_d;
      count_d      = cnt_t'(DEPTH);
    end else begin
      if (grant) begin
        head_alloc_d = ptr_add(head_alloc_q, alloc_n);
      end
      // Overfill is the caller's problem; no clamping here.
      c       = int'(count_q) + int'(ret_n) - (grant ? int'(alloc_n) : 0);
      count_d = cnt_t'(c);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      // Architectural registers own tags 0..ARCH-1; the rest start free.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= tag_t'(ARCH + i);
      end
      head_alloc_q  <= '0;
      head_retire_q <= '0;
      tail_q        <= '0;
      count_q       <= cnt_t'(DEPTH);
    end else begin
      // Retirement still lands during recovery: the RRAT updates that cycle.
      for (int i = 0; i < WAYS; i++) begin
        if (fl.retire_en[i]) begin
          mem[wr_ptr[i]] <= fl.retire_old_idx[i];
        end
      end
      head_alloc_q  <= head_alloc_d;
      head_retire_q <= head_retire_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
    end
  end

`ifdef FREELIST_CHECK_EN
  // ---------------------------------------------------------------------------
  // Protocol checks: overfill and duplicate returned tags in one cycle.
  // ---------------------------------------------------------------------------
  logic dup_tag;
  logic over_fill;

  always_comb begin : dup_check
    dup_tag = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      for (int j = i + 1; j < WAYS; j++) begin
        if (fl.retire_en[i] && fl.retire_en[j] &&
            (fl.retire_old_idx[i] == fl.retire_old_idx[j])) begin
          dup_tag = 1'b1;
        end
      end
    end
  end

  // Judged against the pre-recovery count, so an except cycle still flags it.
  assign over_fill = (int'(count_q) + int'(ret_n)) > DEPTH;

  always_ff @(posedge clock) begin
    if (reset) begin
      err <= 1'b0;
    end else if (dup_tag || over_fill) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: directed test-plan steps followed by a random phase,
// all checked against a queue model of the free tags and outstanding tags.
module tb_free_list;
  localparam int WAYS  = 4;
  localparam int PRF   = 64;
  localparam int ARCH  = 32;
  localparam int DEPTH = PRF - ARCH;

  logic clock = 1'b0;
  logic reset;
  logic except;

  always #5 clock = ~clock;

  free_list_if #(.WAYS(WAYS), .PRF(PRF), .ARCH(ARCH)) fl ();

`ifdef FREELIST_CHECK_EN
  logic err;
`endif

  free_list #(.WAYS(WAYS), .PRF(PRF), .ARCH(ARCH)) dut (
    .clock  (clock),
    .reset  (reset),
    .except (except),
    .fl     (fl.slave)
`ifdef FREELIST_CHECK_EN
    ,
    .err    (err)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: free_q = tags available, oldest first; spec_q = tags handed out
  // and not yet retired, oldest first.
  logic [5:0] free_q[$];
  logic [5:0] spec_q[$];
  bit         m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    free_q.delete();
    spec_q.delete();
    for (int i = 0; i < DEPTH; i++) free_q.push_back(6'(ARCH + i));
    m_err = 1'b0;
  endtask

  // Past the last free tag the ring continues with the oldest outstanding one.
  function automatic logic [5:0] ring_at(input int k);
    if (k < free_q.size()) return free_q[k];
    if (k - free_q.size() < spec_q.size()) return spec_q[k - free_q.size()];
    return 6'd0;
  endfunction

  task automatic drive(input logic [3:0] req, input logic [3:0] ren,
                       input logic [5:0] o0, input logic [5:0] o1,
                       input logic [5:0] o2, input logic [5:0] o3,
                       input logic exc);
    fl.alloc_req      = req;
    fl.retire_en      = ren;
    fl.retire_old_idx = {o3, o2, o1, o0};
    except            = exc;
  endtask

  task automatic chk_model();
    int n;
    int rank;
    n = $countones(fl.alloc_req);
    check("alloc_ok", 32'(n <= free_q.size()), 32'(fl.alloc_ok));
    check("free_count", 32'(fl.free_count), free_q.size());
    rank = 0;
    for (int i = 0; i < WAYS; i++) begin
      if (fl.alloc_req[i]) begin
        check($sformatf("alloc_idx[%0d]", i), 32'(fl.alloc_idx[i]), 32'(ring_at(rank)));
        rank++;
      end else begin
        check($sformatf("idle_idx[%0d]", i), 32'(fl.alloc_idx[i]), 32'(ring_at(0)));
      end
    end
`ifdef FREELIST_CHECK_EN
    check("err", 32'(err), 32'(m_err));
`endif
  endtask

  task automatic model_tick();
    int  n;
    int  r;
    bit  ok;
    bit  dup;
    n  = $countones(fl.alloc_req);
    r  = $countones(fl.retire_en);
    ok = (n <= free_q.size());
    dup = 1'b0;
    for (int i = 0; i < WAYS; i++)
      for (int j = i + 1; j < WAYS; j++)
        if (fl.retire_en[i] && fl.retire_en[j] &&
            fl.retire_old_idx[i] == fl.retire_old_idx[j]) dup = 1'b1;
    if (free_q.size() + r > DEPTH || dup) m_err = 1'b1;
    // Retire: oldest outstanding tags leave, returned tags join the back.
    for (int k = 0; k < r; k++) if (spec_q.size() > 0) void'(spec_q.pop_front());
    for (int i = 0; i < WAYS; i++) if (fl.retire_en[i]) free_q.push_back(fl.retire_old_idx[i]);
    if (except) begin
      while (spec_q.size() > 0) free_q.push_front(spec_q.pop_back());
    end else if (ok) begin
      for (int k = 0; k < n; k++) spec_q.push_back(free_q.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_tick();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(4'($urandom), 4'($urandom), 6'($urandom), 6'($urandom),
          6'($urandom), 6'($urandom), 1'($urandom));
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    drive(4'd0, 4'd0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0);
  endtask

  initial begin
    logic [3:0] req;
    logic [3:0] ren;
    logic       exc;

    reset = 1'b1;
    drive(4'd0, 4'd0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0);
    repeat (2) @(posedge clock);
    do_reset();

    // Reset contents and first 4-way grant
    drive(4'hf, 4'd0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0);
    @(negedge clock);
    chk_model();
    check("rst_free_count", 32'(fl.free_count), 32);
    check("rst_alloc_ok", 32'(fl.alloc_ok), 1);
    for (int i = 0; i < WAYS; i++) check($sformatf("rst_idx[%0d]", i), 32'(fl.alloc_idx[i]), 32 + i);
    tick();

    @(negedge clock);
    check("second_free_count", 32'(fl.free_count), 28);
    for (int i = 0; i < WAYS; i++) check($sformatf("second_idx[%0d]", i), 32'(fl.alloc_idx[i]), 36 + i);
    tick();

    // Drain to empty
    repeat (6) begin
      @(negedge clock);
      chk_model();
      tick();
    end
    drive(4'b0001, 4'd0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0);
    @(negedge clock);
    chk_model();
    check("empty_ok", 32'(fl.alloc_ok), 0);
    check("empty_count", 32'(fl.free_count), 0);
    tick();

    // Retire into an empty list; no same-cycle bypass, head did not move
    drive(4'b0001, 4'b1010, 6'd0, 6'd5, 6'd0, 6'd9, 1'b0);
    @(negedge clock);
    check("nobypass_ok", 32'(fl.alloc_ok), 0);
    check("nobypass_count", 32'(fl.free_count), 0);
    check("head_unchanged", 32'(fl.alloc_idx[0]), 32);
    tick();
    drive(4'b0011, 4'd0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0);
    @(negedge clock);
    chk_model();
    check("wrap_count", 32'(fl.free_count), 2);
    check("wrap_idx0", 32'(fl.alloc_idx[0]), 5);
    check("wrap_idx1", 32'(fl.alloc_idx[1]), 9);
    tick();

    // Mid-operation reset, then a sparse request
    do_reset();
    drive(4'b0101, 4'd0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0);
    @(negedge clock);
    chk_model();
    check("sparse_idx0", 32'(fl.alloc_idx[0]), 32);
    check("sparse_idx2", 32'(fl.alloc_idx[2]), 33);
    tick();
    drive(4'b0001, 4'd0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0);
    @(negedge clock);
    check("sparse_next", 32'(fl.alloc_idx[0]), 34);
    check("sparse_count", 32'(fl.free_count), 30);
    tick();

    // Exception recovery with a same-cycle retirement
    do_reset();
    repeat (3) begin
      drive(4'hf, 4'd0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0);
      @(negedge clock);
      chk_model();
      tick();
    end
    drive(4'd0, 4'hf, 6'd0, 6'd1, 6'd2, 6'd3, 1'b0);
    @(negedge clock);
    chk_model();
    tick();
    drive(4'hf, 4'b0001, 6'd4, 6'd0, 6'd0, 6'd0, 1'b1);
    @(negedge clock);
    chk_model();
    tick();
    drive(4'b0011, 4'd0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0);
    @(negedge clock);
    chk_model();
    check("exc_count", 32'(fl.free_count), 32);
    check("exc_idx0", 32'(fl.alloc_idx[0]), 37);
    check("exc_idx1", 32'(fl.alloc_idx[1]), 38);
    tick();

    // Random phase; retirement never exceeds outstanding allocations
    for (int cyc = 0; cyc < 400; cyc++) begin
      req = 4'($urandom);
      ren = 4'($urandom) & 4'($urandom);
      for (int i = WAYS - 1; i >= 0; i--)
        if ($countones(ren) > spec_q.size()) ren[i] = 1'b0;
      exc = ($urandom_range(0, 15) == 0);
      drive(req, ren, 6'($urandom), 6'($urandom), 6'($urandom), 6'($urandom), exc);
      @(negedge clock);
      chk_model();
      tick();
    end

`ifdef FREELIST_CHECK_EN
    // Overfill from reset, held until reset
    do_reset();
    @(negedge clock);
    check("err_reset", 32'(err), 0);
    drive(4'd0, 4'b0001, 6'd7, 6'd0, 6'd0, 6'd0, 1'b0);
    tick();
    drive(4'd0, 4'd0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0);
    @(negedge clock);
    check("err_overfill", 32'(err), 1);
    tick();
    tick();
    @(negedge clock);
    check("err_sticky", 32'(err), 1);
    do_reset();
    @(negedge clock);
    check("err_cleared", 32'(err), 0);
    // Duplicate returned tags
    drive(4'hf, 4'd0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0);
    tick();
    drive(4'd0, 4'b0011, 6'd10, 6'd10, 6'd0, 6'd0, 1'b0);
    tick();
    drive(4'd0, 4'd0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0);
    @(negedge clock);
    check("err_dup", 32'(err), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
